// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: FSM state encoding and the
// iteration-counter width helper used by the sequential divider.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter must be able to reach W itself, hence W+1 values.
  function automatic int cw_of(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// Load/run handshake and result bus of the sequential divider.
interface div_seq_if #(parameter int W = 4);
  import arith_pkg::*;

  localparam int CW = cw_of(W);

  logic          ld;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  rq;
  logic [W-1:0]  rr;
  logic [CW-1:0] q;
  logic          busy;
  logic          done;
  logic          dz;

  modport master (output ld, a, b, input rq, rr, q, busy, done, dz);
  modport slave  (input ld, a, b, output rq, rr, q, busy, done, dz);

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: W+1-bit trial subtract of the divisor
// from the shifted partial remainder, yielding next remainder and quotient bit.
module div_step #(parameter int W = 4) (
  input  logic [W-1:0] rr,
  input  logic         msb,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rr_next,
  output logic         qbit
);

  logic [W:0] t;

  // A set top bit of the trial difference means the subtract underflowed.
  always_comb begin
    t       = {rr, msb} - {1'b0, divisor};
    qbit    = ~t[W];
    rr_next = qbit ? t[W-1:0] : {rr[W-2:0], msb};
  end

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per clock, ld-driven
// load/run control, with divide-by-zero short-circuited straight to DONE.
module div_seq
  import arith_pkg::*;
#(parameter int W = 4) (
  input  logic       clk,
  input  logic       rst,
  div_seq_if.slave   bus
);

  localparam int CW = cw_of(W);

  state_t       state;
  logic [W-1:0] divisor;
  logic [W-1:0] rr_next;
  logic         qbit;

  div_step #(.W(W)) u_step (
    .rr      (bus.rr),
    .msb     (bus.rq[W-1]),
    .divisor (divisor),
    .rr_next (rr_next),
    .qbit    (qbit)
  );

  // ld wins in every state, so a new load mid-run simply discards the old work.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      divisor  <= '0;
      bus.rq   <= '0;
      bus.rr   <= '0;
      bus.q    <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.dz   <= 1'b0;
    end else if (bus.ld) begin
      bus.q <= '0;
      if (bus.b != '0) begin
        state    <= ST_RUN;
        divisor  <= bus.b;
        bus.rq   <= bus.a;
        bus.rr   <= '0;
        bus.dz   <= 1'b0;
        bus.busy <= 1'b1;
        bus.done <= 1'b0;
      end else begin
        state    <= ST_DONE;
        bus.rq   <= '1;
        bus.rr   <= bus.a;
        bus.dz   <= 1'b1;
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
      end
    end else if (state == ST_RUN) begin
      bus.rr <= rr_next;
      bus.rq <= {bus.rq[W-2:0], qbit};
      bus.q  <= bus.q + CW'(1);
      if (bus.q == CW'(W-1)) begin
        state    <= ST_DONE;
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq at W=4 and W=8.
module tb_div_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  div_seq_if #(.W(4)) bus4 ();
  div_seq_if #(.W(8)) bus8 ();

  div_seq #(.W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  div_seq #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] a, input logic [3:0] b);
    bus4.a  = a;
    bus4.b  = b;
    bus4.ld = 1'b1;
    step(1);
    bus4.ld = 1'b0;
  endtask

  task automatic check_result4(input string tag, input int rq, input int rr);
    check_output({tag, "_done"}, 32'(bus4.done), 1);
    check_output({tag, "_busy"}, 32'(bus4.busy), 0);
    check_output({tag, "_rq"},   32'(bus4.rq),   rq);
    check_output({tag, "_rr"},   32'(bus4.rr),   rr);
  endtask

  initial begin
    int va [7];
    int vb [7];
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    bus4.ld = 1'b0;
    bus4.a  = '0;
    bus4.b  = '0;
    bus8.ld = 1'b0;
    bus8.a  = '0;
    bus8.b  = '0;

    step(2);
    check_output("rst_rq",   32'(bus4.rq),   0);
    check_output("rst_busy", 32'(bus4.busy), 0);
    check_output("rst_done", 32'(bus4.done), 0);
    rst = 1'b1;
    step(2);
    check_output("idle_busy", 32'(bus4.busy), 0);
    check_output("idle_done", 32'(bus4.done), 0);

    // 13/3: busy for four cycles, then the result holds
    apply_stimulus(4'd13, 4'd3);
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("t1_busy%0d", i), 32'(bus4.busy), 1);
      check_output($sformatf("t1_q%0d", i),    32'(bus4.q),    i);
      step(1);
    end
    check_result4("t1", 4, 1);
    check_output("t1_q",  32'(bus4.q),  4);
    check_output("t1_dz", 32'(bus4.dz), 0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check_output($sformatf("t1_hold_rq%0d", i), 32'(bus4.rq), 4);
      check_output($sformatf("t1_hold_rr%0d", i), 32'(bus4.rr), 1);
      check_output($sformatf("t1_hold_q%0d", i),  32'(bus4.q),  4);
    end

    // divide by zero finishes on the load edge
    apply_stimulus(4'd7, 4'd0);
    check_result4("t2", 15, 7);
    check_output("t2_dz", 32'(bus4.dz), 1);
    check_output("t2_q",  32'(bus4.q),  0);

    apply_stimulus(4'd15, 4'd1);  step(4); check_result4("t3a", 15, 0);
    apply_stimulus(4'd0,  4'd5);  step(4); check_result4("t3b", 0, 0);
    apply_stimulus(4'd15, 4'd15); step(4); check_result4("t3c", 1, 0);
    apply_stimulus(4'd5,  4'd9);  step(4); check_result4("t3d", 0, 5);
    check_output("t3d_dz", 32'(bus4.dz), 0);

    // reload mid-run discards the first division
    apply_stimulus(4'd14, 4'd4);
    step(2);
    apply_stimulus(4'd9, 4'd2);
    step(3);
    check_output("t4_busy3", 32'(bus4.busy), 1);
    step(1);
    check_result4("t4", 4, 1);

    // operand changes while running are ignored
    apply_stimulus(4'd13, 4'd3);
    bus4.a = 4'd2;
    bus4.b = 4'd0;
    step(4);
    check_result4("t4b", 4, 1);

    // ld held for three edges keeps reloading
    bus4.a  = 4'd6;
    bus4.b  = 4'd4;
    bus4.ld = 1'b1;
    step(3);
    bus4.ld = 1'b0;
    check_output("t4c_q0",    32'(bus4.q),    0);
    check_output("t4c_busy0", 32'(bus4.busy), 1);
    step(4);
    check_result4("t4c", 1, 2);

    // asynchronous reset mid-run
    apply_stimulus(4'd11, 4'd2);
    step(2);
    rst = 1'b0;
    #1;
    check_output("t5_rq",   32'(bus4.rq),   0);
    check_output("t5_rr",   32'(bus4.rr),   0);
    check_output("t5_q",    32'(bus4.q),    0);
    check_output("t5_busy", 32'(bus4.busy), 0);
    check_output("t5_done", 32'(bus4.done), 0);
    check_output("t5_dz",   32'(bus4.dz),   0);
    step(1);
    rst = 1'b1;
    step(3);
    check_output("t5_idle_busy", 32'(bus4.busy), 0);
    check_output("t5_idle_done", 32'(bus4.done), 0);
    check_output("t5_idle_q",    32'(bus4.q),    0);

    // W=8 directed vectors, done exactly eight cycles after ld
    va = '{200, 255, 255, 0, 37, 128, 99};
    vb = '{7,   1,   255, 9, 0,  200, 10};
    for (int i = 0; i < 7; i++) begin
      bus8.a  = 8'(va[i]);
      bus8.b  = 8'(vb[i]);
      bus8.ld = 1'b1;
      step(1);
      bus8.ld = 1'b0;
      if (vb[i] == 0) begin
        check_output($sformatf("w8_%0d_dz", i), 32'(bus8.dz),   1);
        check_output($sformatf("w8_%0d_rq", i), 32'(bus8.rq),   255);
        check_output($sformatf("w8_%0d_rr", i), 32'(bus8.rr),   va[i]);
        check_output($sformatf("w8_%0d_dn", i), 32'(bus8.done), 1);
      end else begin
        step(7);
        check_output($sformatf("w8_%0d_early", i), 32'(bus8.done), 0);
        step(1);
        check_output($sformatf("w8_%0d_done", i), 32'(bus8.done), 1);
        check_output($sformatf("w8_%0d_q", i),    32'(bus8.q),    8);
        check_output($sformatf("w8_%0d_rq", i),   32'(bus8.rq),   va[i] / vb[i]);
        check_output($sformatf("w8_%0d_rr", i),   32'(bus8.rr),   va[i] % vb[i]);
        check_output($sformatf("w8_%0d_dz", i),   32'(bus8.dz),   0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
